mulctl_precision_packer: RTL and testbench
==========================================

Name: mulctl_precision_packer

Overview:
- Issue controller for the 8x8 precision-configurable registered multiplier. HALF_1 mode splits that multiplier into two 4x4 lanes: lane L takes A[3:0]*B[3:0] and returns C[7:0]; lane H takes A[7:4]*B[7:4] and returns C[15:8].
- Accepts a stream of tagged multiply requests, each either full 8x8 or half 4x4.
- Pairs consecutive compatible half requests into one half-mode issue.
- Drives the multiplier, tracks its pipeline latency, and returns one result per request, in order, through a result FIFO with valid/ready.

Parameters:
- TAG_W, 4, width of the request tag carried to the result.
- FIFO_DEPTH, 4, result FIFO entries; must be at least 2.
- MUL_LATENCY, 1, cycles from issue to a valid mul_C.
- PAIR_TIMEOUT, 4, idle cycles a held half request waits for a partner before it issues alone; must be at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid and in_ready are both high.
- in_a  in  8  operand A; only [3:0] is used in half mode.
- in_b  in  8  operand B; only [3:0] is used in half mode.
- in_sign_a  in  1  A is signed.
- in_sign_b  in  1  B is signed.
- in_half  in  1  1 = 4x4 request, 0 = 8x8 request.
- in_tag  in  TAG_W  request tag.
- flush  in  1  forces a held half request to issue alone.
- mul_A  out  8  multiplier A operand.
- mul_B  out  8  multiplier B operand.
- mul_A_sign  out  1  multiplier A sign control.
- mul_B_sign  out  1  multiplier B sign control.
- mul_HALF_0  out  1  multiplier half-mode level 0.
- mul_HALF_1  out  1  multiplier half-mode level 1.
- mul_C  in  16  registered multiplier product.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid and out_ready are both high.
- out_p  out  16  product; half results are extended to 16 bits.
- out_half  out  1  mode of the originating request.
- out_tag  out  TAG_W  tag of the originating request.

Behaviour:
- Reset, asynchronous and active-low, applies to all state:
  - FSM goes to EMPTY; pipeline, FIFO and timer are cleared.
  - All mul_* outputs are 0; in_ready = 0 while reset is asserted; out_valid = 0, out_p = 0, out_tag = 0, out_half = 0.
  - Reset mid-operation discards held, in-flight and queued results.
- Credit rule:
  - free = FIFO_DEPTH − fifo_count − inflight_results.
  - in_ready = 1 only when free ≥ 2 and the FSM is not in a forced-single cycle.
- FSM state EMPTY:
  - Accepted full request: issue a full multiply that same cycle. mul_A/mul_B = in_a/in_b; signs = request signs; HALF_0 = HALF_1 = 0.
  - Accepted half request: latch it into the hold register, clear the timer, go to HOLD. No issue.
- FSM state HOLD, highest priority first:
  1. flush = 1: the held request issues alone; in_ready = 0; go to EMPTY.
  2. in_valid with in_half = 1 and both signs equal to the held request's signs: accept it and issue a pair. mul_A = {new_a[3:0], held_a[3:0]}, likewise mul_B; signs = shared signs; HALF_0 = HALF_1 = 1. Go to EMPTY.
  3. in_valid with a full request or a sign mismatch (forced-single): in_ready = 0; issue the held request alone; go to EMPTY. The new request is accepted on a later cycle.
  4. No in_valid: timer increments. At timer == PAIR_TIMEOUT−1 the held request issues alone and the FSM goes to EMPTY.
- Single half issue: upper nibbles of mul_A/mul_B are 0, HALF bits are 1, and the lane H result is discarded.
- Idle cycles (no issue): mul_* = 0.
- Issue pipeline:
  - A MUL_LATENCY-deep shift register carries, per issue: valid, pair flag, mode, signs, and both tags.
  - At its tail, mul_C is captured into the FIFO.
  - Full issue: one entry, out_p = mul_C.
  - Half issue: lane L is written first. Its out_p = C[7:0], sign-extended if (sign_a | sign_b), otherwise zero-extended.
  - Paired issue: lane H is written second, into the same cycle's second write slot. Its out_p = C[15:8], extended by the same rule.
  - The FIFO therefore supports 2 writes per cycle.
- Ordering: results leave in acceptance order; the held request is always older than its partner.
- FIFO behaviour:
  - Simultaneous write and read are allowed.
  - Full never occurs, because credits are reserved at accept.
  - When empty, out_valid = 0 and out_p holds its last value.

Test Plan:
- Full signed: a=0xF6 (−10), b=0x07, signs 1/1, out_ready=1 → one issue with HALF_1 = 0; out_p = 0xFFBA (−70), out_half = 0, tag preserved; out_valid rises 1 + MUL_LATENCY cycles after accept.
- Pair: half a=0x3, b=0x5 tag 1, then half a=0xE (−2), b=0x3 tag 2, both signed → single issue with mul_A = 0xE3, mul_B = 0x35, HALF_0 = HALF_1 = 1; results tag1 = 0x000F, then tag2 = 0xFFFA.
- Forced-single: held half (a=0x2, b=0x2, unsigned) then full request → in_ready = 0 for one cycle; held request issues alone with mul_A = 0x02; outputs 0x0004, then the full product, in order.
- Timeout: one unsigned half a=0xF, b=0xF, no further input, PAIR_TIMEOUT = 4 → issues on the 4th idle cycle; out_p = 0x00E1.
- Backpressure: out_ready = 0, continuous full requests → in_ready drops once free < 2; no result is lost; releasing out_ready drains all results in order.
- Reset: assert reset in HOLD with results in flight → all outputs 0 immediately (asynchronous); after release no stale results appear and the FSM is in EMPTY.

Source files
------------

// File: rtl/mulctl_precision_packer.sv
// Issue controller for an 8x8 precision-configurable registered multiplier.
// Pairs compatible 4x4 requests into one half-mode issue and returns results in order.
module mulctl_precision_packer #(
    parameter int TAG_W        = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int MUL_LATENCY  = 1,
    parameter int PAIR_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_sign_a,
    input  logic             in_sign_b,
    input  logic             in_half,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic [7:0]       mul_A,
    output logic [7:0]       mul_B,
    output logic             mul_A_sign,
    output logic             mul_B_sign,
    output logic             mul_HALF_0,
    output logic             mul_HALF_1,
    input  logic [15:0]      mul_C,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_p,
    output logic             out_half,
    output logic [TAG_W-1:0] out_tag,
    output logic             dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid and payload hold until that edge, and ready never depends on a later valid.
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = (PAIR_TIMEOUT > 1) ? $clog2(PAIR_TIMEOUT) : 1;

    typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_t;

    typedef struct packed {
        logic             valid;
        logic             pair;
        logic             half;
        logic             sext;
        logic [TAG_W-1:0] tag_l;
        logic [TAG_W-1:0] tag_h;
    } pipe_t;

    typedef struct packed {
        logic [15:0]      p;
        logic             half;
        logic [TAG_W-1:0] tag;
    } entry_t;

    function automatic logic [15:0] ext8(input logic [7:0] v, input logic s);
        return {{8{s & v[7]}}, v};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [3:0]         hold_a_q, hold_b_q;
    logic               hold_sa_q, hold_sb_q;
    logic [TAG_W-1:0]   hold_tag_q;
    logic               hold_load, do_full, do_single, do_pair;
    pipe_t              issue;
    pipe_t              pipe_q [MUL_LATENCY];
    pipe_t              tail;
    entry_t             mem_q [FIFO_DEPTH];
    entry_t             last_q, e0, e1;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        inflight, used;
    logic               credit_ok, sign_match, wr0_en, wr1_en, pop;

    assign dbg_state = state_q;

    // Results already owed: queued entries plus everything still in the pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            if (pipe_q[i].valid) inflight = inflight + (pipe_q[i].pair ? 32'd2 : 32'd1);
        end
    end
    assign used       = 32'(cnt_q) + inflight;
    assign credit_ok  = (used + 32'd2) <= 32'(FIFO_DEPTH);
    assign sign_match = (in_sign_a == hold_sa_q) && (in_sign_b == hold_sb_q);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        hold_load = 1'b0;
        in_ready  = 1'b0;
        do_full   = 1'b0;
        do_single = 1'b0;
        do_pair   = 1'b0;
        case (state_q)
            S_EMPTY: begin
                in_ready = reset & credit_ok;
                if (in_valid && in_ready) begin
                    if (in_half) begin
                        hold_load = 1'b1;
                        timer_d   = '0;
                        state_d   = S_HOLD;
                    end else begin
                        do_full = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    do_single = 1'b1;
                end else if (in_valid && !(in_half && sign_match)) begin
                    do_single = 1'b1;
                end else if (in_valid && credit_ok) begin
                    in_ready = 1'b1;
                    do_pair  = 1'b1;
                end else if (timer_q == TMR_W'(PAIR_TIMEOUT - 1)) begin
                    do_single = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
                if (do_single || do_pair) begin
                    state_d = S_EMPTY;
                    timer_d = '0;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        mul_A      = '0;
        mul_B      = '0;
        mul_A_sign = 1'b0;
        mul_B_sign = 1'b0;
        mul_HALF_0 = 1'b0;
        mul_HALF_1 = 1'b0;
        issue      = '0;
        if (do_full) begin
            mul_A       = in_a;
            mul_B       = in_b;
            mul_A_sign  = in_sign_a;
            mul_B_sign  = in_sign_b;
            issue.valid = 1'b1;
            issue.tag_l = in_tag;
        end else if (do_single || do_pair) begin
            // The held request always rides lane L; a partner takes lane H.
            mul_A       = {do_pair ? in_a[3:0] : 4'h0, hold_a_q};
            mul_B       = {do_pair ? in_b[3:0] : 4'h0, hold_b_q};
            mul_A_sign  = hold_sa_q;
            mul_B_sign  = hold_sb_q;
            mul_HALF_0  = 1'b1;
            mul_HALF_1  = 1'b1;
            issue.valid = 1'b1;
            issue.pair  = do_pair;
            issue.half  = 1'b1;
            issue.sext  = hold_sa_q | hold_sb_q;
            issue.tag_l = hold_tag_q;
            issue.tag_h = do_pair ? in_tag : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_EMPTY;
            timer_q    <= '0;
            hold_a_q   <= '0;
            hold_b_q   <= '0;
            hold_sa_q  <= 1'b0;
            hold_sb_q  <= 1'b0;
            hold_tag_q <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (hold_load) begin
                hold_a_q   <= in_a[3:0];
                hold_b_q   <= in_b[3:0];
                hold_sa_q  <= in_sign_a;
                hold_sb_q  <= in_sign_b;
                hold_tag_q <= in_tag;
            end
            pipe_q[0] <= issue;
            for (int i = 1; i < MUL_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tail   = pipe_q[MUL_LATENCY-1];
    assign wr0_en = tail.valid;
    assign wr1_en = tail.valid & tail.pair;
    assign e0     = '{p: tail.half ? ext8(mul_C[7:0], tail.sext) : mul_C,
                      half: tail.half, tag: tail.tag_l};
    assign e1     = '{p: ext8(mul_C[15:8], tail.sext), half: 1'b1, tag: tail.tag_h};
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
        end else begin
            if (wr0_en) mem_q[wr_ptr_q] <= e0;
            if (wr1_en) mem_q[ptr_inc(wr_ptr_q)] <= e1;
            if (wr1_en)      wr_ptr_q <= ptr_inc(ptr_inc(wr_ptr_q));
            else if (wr0_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
                last_q   <= mem_q[rd_ptr_q];
            end
            cnt_q <= cnt_q + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(pop);
        end
    end

    // An empty queue keeps presenting the most recently consumed result.
    assign out_p    = out_valid ? mem_q[rd_ptr_q].p    : last_q.p;
    assign out_half = out_valid ? mem_q[rd_ptr_q].half : last_q.half;
    assign out_tag  = out_valid ? mem_q[rd_ptr_q].tag  : last_q.tag;

endmodule

// File: tb/tb_mulctl_precision_packer.sv
// Bench for mulctl_precision_packer: behavioural multiplier, exact-arithmetic
// reference for every result, directed scenarios plus a randomized stream.
module tb_mulctl_precision_packer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [7:0]  in_a = '0, in_b = '0;
    logic        in_sign_a = 1'b0, in_sign_b = 1'b0, in_half = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic [7:0]  mul_A, mul_B;
    logic        mul_A_sign, mul_B_sign, mul_HALF_0, mul_HALF_1;
    logic [15:0] mul_C = '0;
    logic        out_valid, out_ready = 1'b0, out_half, dbg_state;
    logic [15:0] out_p;
    logic [3:0]  out_tag;

    int checks = 0;
    int errors = 0;
    int oready_mode = 0;
    logic [20:0] exp_q[$];
    logic [20:0] got_q[$];
    logic        f_ready, acc_h0, acc_h1;
    logic [7:0]  f_mul_a, acc_mul_a, acc_mul_b;
    logic        f_h1;
    int          last_waits;

    mulctl_precision_packer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sign_a(in_sign_a), .in_sign_b(in_sign_b),
        .in_half(in_half), .in_tag(in_tag), .flush(flush),
        .mul_A(mul_A), .mul_B(mul_B), .mul_A_sign(mul_A_sign), .mul_B_sign(mul_B_sign),
        .mul_HALF_0(mul_HALF_0), .mul_HALF_1(mul_HALF_1), .mul_C(mul_C),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .out_half(out_half), .out_tag(out_tag), .dbg_state(dbg_state)
    );

    // ---- clock ----
    always #5 clk = ~clk;

    // Exact mathematical product of the operands, truncated to 16 bits.
    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                             input logic sa, input logic sb, input logic half);
        int va, vb;
        if (half) begin
            va = sa ? int'($signed(a[3:0])) : int'(a[3:0]);
            vb = sb ? int'($signed(b[3:0])) : int'(b[3:0]);
        end else begin
            va = sa ? int'($signed(a)) : int'(a);
            vb = sb ? int'($signed(b)) : int'(b);
        end
        return 16'(va * vb);
    endfunction

    // ---- behavioural registered multiplier (latency 1) ----
    logic [15:0] m_lo, m_hi, m_full;
    always_comb begin
        m_lo   = ref_prod({4'h0, mul_A[3:0]}, {4'h0, mul_B[3:0]}, mul_A_sign, mul_B_sign, 1'b1);
        m_hi   = ref_prod({4'h0, mul_A[7:4]}, {4'h0, mul_B[7:4]}, mul_A_sign, mul_B_sign, 1'b1);
        m_full = ref_prod(mul_A, mul_B, mul_A_sign, mul_B_sign, 1'b0);
    end
    always @(posedge clk) mul_C <= mul_HALF_1 ? {m_hi[7:0], m_lo[7:0]} : m_full;

    // ---- out_ready driver and result monitor ----
    always @(posedge clk) begin
        #1;
        case (oready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) got_q.push_back({out_half, out_tag, out_p});
    end

    // ---- driver tasks ----
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sa,
                        input logic sb, input logic half, input logic [3:0] tag);
        int waits;
        waits = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_sign_a = sa; in_sign_b = sb;
        in_half = half; in_tag = tag;
        @(negedge clk);
        f_ready = in_ready; f_mul_a = mul_A; f_h1 = mul_HALF_1;
        while (!in_ready && waits < 200) begin
            @(posedge clk); #1;
            waits++;
            @(negedge clk);
        end
        if (in_ready) begin
            acc_mul_a = mul_A; acc_mul_b = mul_B; acc_h0 = mul_HALF_0; acc_h1 = mul_HALF_1;
            exp_q.push_back({half, tag, ref_prod(a, b, sa, sb, half)});
        end else begin
            checks++; errors++;
            $display("FAIL send_accept: tag %0d never accepted, in_ready=%b required 1", tag, in_ready);
        end
        last_waits = waits;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && got_q.size() < exp_q.size(); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        in_valid = 1'b1; in_a = 8'h55; in_b = 8'h33; in_half = 1'b0;
        #12;
        checks += 8;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        if (mul_A !== 8'h00 || mul_B !== 8'h00) begin errors++; $display("FAIL rst_mul_ab: got %h/%h want 00/00", mul_A, mul_B); end
        if (mul_HALF_0 !== 1'b0 || mul_HALF_1 !== 1'b0 || mul_A_sign !== 1'b0 || mul_B_sign !== 1'b0) begin
            errors++; $display("FAIL rst_mul_ctl: got %b%b%b%b want 0000", mul_HALF_0, mul_HALF_1, mul_A_sign, mul_B_sign);
        end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (out_p !== 16'h0) begin errors++; $display("FAIL rst_out_p: got %h want 0000", out_p); end
        if (out_tag !== 4'h0) begin errors++; $display("FAIL rst_out_tag: got %h want 0", out_tag); end
        if (out_half !== 1'b0) begin errors++; $display("FAIL rst_out_half: got %b want 0", out_half); end
        if (dbg_state !== 1'b0) begin errors++; $display("FAIL rst_state: got %b want EMPTY", dbg_state); end
        in_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_full_signed();
        clear_q(); oready_mode = 1;
        @(posedge clk); #1;
        send(8'hF6, 8'h07, 1'b1, 1'b1, 1'b0, 4'd5);
        checks += 2;
        if (acc_h1 !== 1'b0 || acc_h0 !== 1'b0) begin errors++; $display("FAIL full_half_bits: got %b%b want 00", acc_h0, acc_h1); end
        if (acc_mul_a !== 8'hF6 || acc_mul_b !== 8'h07) begin errors++; $display("FAIL full_operands: got %h/%h want f6/07", acc_mul_a, acc_mul_b); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL full_latency_early: out_valid %b want 0", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL full_latency: out_valid %b want 1", out_valid); end
        drain();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {1'b0, 4'd5, 16'hFFBA}) begin
            errors++; $display("FAIL full_result: got %0d entries first %h want 1 entry %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 21'h0, {1'b0, 4'd5, 16'hFFBA});
        end
    endtask

    task automatic test_pair();
        clear_q();
        send(8'h03, 8'h05, 1'b1, 1'b1, 1'b1, 4'd1);
        send(8'h0E, 8'h03, 1'b1, 1'b1, 1'b1, 4'd2);
        checks += 2;
        if (acc_mul_a !== 8'hE3 || acc_mul_b !== 8'h35) begin errors++; $display("FAIL pair_operands: got %h/%h want e3/35", acc_mul_a, acc_mul_b); end
        if (acc_h0 !== 1'b1 || acc_h1 !== 1'b1) begin errors++; $display("FAIL pair_half_bits: got %b%b want 11", acc_h0, acc_h1); end
        drain();
        checks++;
        if (got_q.size() != 2 || got_q[0] !== {1'b1, 4'd1, 16'h000F} || got_q[1] !== {1'b1, 4'd2, 16'hFFFA}) begin
            errors++; $display("FAIL pair_results: got %0d entries %h %h want %h %h", got_q.size(),
                (got_q.size() > 0) ? got_q[0] : 21'h0, (got_q.size() > 1) ? got_q[1] : 21'h0,
                {1'b1, 4'd1, 16'h000F}, {1'b1, 4'd2, 16'hFFFA});
        end
    endtask

    task automatic test_forced_single();
        clear_q();
        send(8'h02, 8'h02, 1'b0, 1'b0, 1'b1, 4'd3);
        send(8'h10, 8'h03, 1'b0, 1'b0, 1'b0, 4'd4);
        checks += 3;
        if (f_ready !== 1'b0 || last_waits != 1) begin errors++; $display("FAIL forced_ready: first in_ready %b waits %0d want 0/1", f_ready, last_waits); end
        if (f_mul_a !== 8'h02 || f_h1 !== 1'b1) begin errors++; $display("FAIL forced_issue: mul_A %h half %b want 02/1", f_mul_a, f_h1); end
        if (acc_mul_a !== 8'h10 || acc_h1 !== 1'b0) begin errors++; $display("FAIL forced_full_issue: mul_A %h half %b want 10/0", acc_mul_a, acc_h1); end
        drain();
        checks++;
        if (got_q.size() != 2 || got_q[0] !== {1'b1, 4'd3, 16'h0004} || got_q[1] !== {1'b0, 4'd4, 16'h0030}) begin
            errors++; $display("FAIL forced_results: got %0d entries %h %h want %h %h", got_q.size(),
                (got_q.size() > 0) ? got_q[0] : 21'h0, (got_q.size() > 1) ? got_q[1] : 21'h0,
                {1'b1, 4'd3, 16'h0004}, {1'b0, 4'd4, 16'h0030});
        end
    endtask

    task automatic test_timeout();
        int n;
        logic [7:0] a_seen;
        clear_q();
        send(8'h0F, 8'h0F, 1'b0, 1'b0, 1'b1, 4'd6);
        n = 0; a_seen = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (mul_HALF_1 && n == 0) begin n = i; a_seen = mul_A; end
        end
        checks += 2;
        if (n != 4) begin errors++; $display("FAIL timeout_cycle: issued on idle cycle %0d want 4", n); end
        if (a_seen !== 8'h0F) begin errors++; $display("FAIL timeout_operand: mul_A %h want 0f", a_seen); end
        drain();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {1'b1, 4'd6, 16'h00E1}) begin
            errors++; $display("FAIL timeout_result: got %0d entries first %h want %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 21'h0, {1'b1, 4'd6, 16'h00E1});
        end
    endtask

    task automatic test_back_to_back();
        int n_acc;
        clear_q(); oready_mode = 0;
        @(posedge clk); #1;
        n_acc = 0;
        in_a = 8'($urandom); in_b = 8'($urandom); in_sign_a = 1'($urandom); in_sign_b = 1'($urandom);
        in_half = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_tag = 4'(n_acc);
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({1'b0, in_tag, ref_prod(in_a, in_b, in_sign_a, in_sign_b, 1'b0)});
                n_acc++;
                @(posedge clk); #1;
                in_a = 8'($urandom); in_b = 8'($urandom); in_sign_a = 1'($urandom); in_sign_b = 1'($urandom);
            end else begin
                @(posedge clk); #1;
            end
        end
        checks += 2;
        if (n_acc != 3) begin errors++; $display("FAIL bp_accepts: accepted %0d want 3", n_acc); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: in_ready %b want 0", in_ready); end
        in_valid = 1'b0; oready_mode = 1;
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_entry[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        clear_q(); oready_mode = 2;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                flush = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1; flush = 1'b0;
            end
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0), 4'(n));
        end
        oready_mode = 1;
        repeat (6) @(posedge clk);
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_entry[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_q(); oready_mode = 0;
        @(posedge clk); #1;
        send(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 4'd1);
        send(8'h05, 8'h06, 1'b0, 1'b0, 1'b1, 4'd2);
        checks += 2;
        if (dbg_state !== 1'b1) begin errors++; $display("FAIL mid_pre_state: got %b want HOLD", dbg_state); end
        if (out_valid !== 1'b1 || out_p !== 16'h03A8) begin errors++; $display("FAIL mid_pre_out: valid %b p %h want 1/03a8", out_valid, out_p); end
        #2 reset = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0 || out_p !== 16'h0) begin errors++; $display("FAIL mid_rst_out: valid %b p %h want 0/0000", out_valid, out_p); end
        if (out_tag !== 4'h0 || out_half !== 1'b0) begin errors++; $display("FAIL mid_rst_meta: tag %h half %b want 0/0", out_tag, out_half); end
        if (in_ready !== 1'b0 || dbg_state !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl: ready %b state %b want 0/0", in_ready, dbg_state); end
        if (mul_A !== 8'h0 || mul_HALF_1 !== 1'b0) begin errors++; $display("FAIL mid_rst_mul: A %h half %b want 00/0", mul_A, mul_HALF_1); end
        @(posedge clk);
        @(negedge clk); reset = 1'b1;
        clear_q(); oready_mode = 1;
        repeat (10) @(posedge clk);
        #1;
        checks += 2;
        if (got_q.size() != 0) begin errors++; $display("FAIL mid_stale: got %0d results want 0", got_q.size()); end
        if (dbg_state !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_post_state: state %b valid %b want 0/0", dbg_state, out_valid); end
        send(8'h03, 8'h03, 1'b0, 1'b0, 1'b0, 4'd7);
        drain();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {1'b0, 4'd7, 16'h0009}) begin
            errors++; $display("FAIL mid_recover: got %0d entries first %h want %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 21'h0, {1'b0, 4'd7, 16'h0009});
        end
    endtask

    // ---- sequence and report ----
    initial begin
        test_reset();
        test_full_signed();
        test_pair();
        test_forced_single();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
